// File: rtl/reward_writer.sv
// Writes one multi-word reward/Q record into mem, one word per clock,
// with an up-front bounds check and a one-cycle done/err pulse.
module reward_writer #(
  parameter int unsigned WORD_WIDTH  = 16,
  parameter int unsigned NUM_WORDS   = 5,
  parameter int unsigned ADDR_STRIDE = 2,
  parameter int unsigned MEM_DEPTH   = 1024
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [WORD_WIDTH*NUM_WORDS-1:0]  record_in,
  input  logic [WORD_WIDTH-1:0]            base_addr,
  output logic [WORD_WIDTH-1:0]            address,
  output logic                             wr_en,
  output logic [WORD_WIDTH-1:0]            mem_data_in,
  output logic                             busy,
  output logic                             done_write,
  output logic                             err
);

  localparam int unsigned REC_W = WORD_WIDTH * NUM_WORDS;
  localparam int unsigned EXT_W = WORD_WIDTH + 1;
  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned SPAN  = NUM_WORDS * ADDR_STRIDE - 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]            state, state_d;
  logic [REC_W-1:0]      rec_q, rec_d;
  logic [IDX_W-1:0]      index_q, index_d;
  logic [WORD_WIDTH-1:0] address_d, data_d;
  logic                  wr_en_d, busy_d, done_d, err_d;
  logic [EXT_W-1:0]      last_c;
  logic                  in_range_c;

  // Last byte touched by the record, widened so a high base cannot wrap.
  assign last_c     = EXT_W'(base_addr) + EXT_W'(SPAN);
  assign in_range_c = (last_c <= EXT_W'(MEM_DEPTH - 1));

  // Next-state and next-output logic; rec_q is a shift register whose top word is next to write.
  always_comb begin
    state_d   = state;
    rec_d     = rec_q;
    index_d   = index_q;
    address_d = address;
    data_d    = mem_data_in;
    wr_en_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (!in_range_c) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d   = S_WRITE;
            rec_d     = record_in << WORD_WIDTH;
            index_d   = '0;
            address_d = base_addr;
            data_d    = record_in[REC_W-1 -: WORD_WIDTH];
            wr_en_d   = 1'b1;
            busy_d    = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (index_q == IDX_W'(NUM_WORDS - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          index_d   = index_q + IDX_W'(1);
          address_d = address + WORD_WIDTH'(ADDR_STRIDE);
          data_d    = rec_q[REC_W-1 -: WORD_WIDTH];
          rec_d     = rec_q << WORD_WIDTH;
          wr_en_d   = 1'b1;
          busy_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight record.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rec_q       <= '0;
      index_q     <= '0;
      address     <= '0;
      mem_data_in <= '0;
      wr_en       <= 1'b0;
      busy        <= 1'b0;
      done_write  <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_d;
      rec_q       <= rec_d;
      index_q     <= index_d;
      address     <= address_d;
      mem_data_in <= data_d;
      wr_en       <= wr_en_d;
      busy        <= busy_d;
      done_write  <= done_d;
      err         <= err_d;
    end
  end

endmodule

// File: tb/tb_reward_writer.sv
// Bench for reward_writer: vector table of records plus scripted busy,
// back-to-back and reset corner cases; writes checked against a scoreboard.
module tb_reward_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [79:0] record_in = '0;
  logic [15:0] base_addr = '0;
  logic [15:0] address;
  logic        wr_en;
  logic [15:0] mem_data_in;
  logic        busy;
  logic        done_write;
  logic        err;

  reward_writer dut (
    .clock(clock), .reset(reset), .start(start), .record_in(record_in),
    .base_addr(base_addr), .address(address), .wr_en(wr_en),
    .mem_data_in(mem_data_in), .busy(busy), .done_write(done_write), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
  typedef struct { logic [15:0] base; logic [79:0] rec; logic exp_err; } vec_t;

  wr_t         exp_q[$];
  logic [15:0] tbmem [0:1023];
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  logic        pend_v = 1'b0;
  wr_t         pend;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory model: a word presented in one cycle lands at the next edge if reset is high then.
  always @(posedge clock) begin
    wr_t w;
    if (pend_v && reset) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", pend.addr, pend.data);
      end else begin
        w = exp_q.pop_front();
        chk("write_addr", 80'(pend.addr), 80'(w.addr));
        chk("write_data", 80'(pend.data), 80'(w.data));
      end
      if (pend.addr < 16'd1024) tbmem[pend.addr[9:0]] = pend.data;
    end
    pend_v = 1'b0;
    #1;
    if (reset) begin
      if (wr_en) begin
        pend.addr = address;
        pend.data = mem_data_in;
        pend_v = 1'b1;
      end
      if (done_write) done_cnt++;
      if (err) chk("err_with_done", 80'(done_write), 80'(1));
    end
  end

  task automatic push_record(input logic [15:0] base, input logic [79:0] rec, input int n);
    wr_t w;
    for (int k = 0; k < n; k++) begin
      w.addr = base + 16'(2 * k);
      w.data = rec[(4 - k) * 16 +: 16];
      exp_q.push_back(w);
    end
  endtask

  // Present a start for one edge; returns at the first sample after that edge (cycle 1).
  task automatic start_rec(input logic [15:0] base, input logic [79:0] rec, input int n_push);
    @(negedge clock);
    base_addr = base;
    record_in = rec;
    start = 1'b1;
    push_record(base, rec, n_push);
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, input int lat, input logic e);
    int c = c0;
    bit got = 1'b0;
    while (!got && c <= c0 + 20) begin
      if (done_write) begin
        got = 1'b1;
        chk("done_latency", 80'(c), 80'(lat));
        chk("done_err", 80'(err), 80'(e));
        chk("done_busy", 80'(busy), 80'(0));
        chk("done_wr_en", 80'(wr_en), 80'(0));
      end else begin
        @(posedge clock);
        #1;
        c++;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done_write, expected one by cycle %0d", lat);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  vec_t vecs[8];
  int   d0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0010, 80'h1111_2222_3333_4444_5555, 1'b0};
    vecs[1] = '{16'h03F8, 80'hAAAA_BBBB_CCCC_DDDD_EEEE, 1'b1};
    vecs[2] = '{16'h03F6, 80'h0123_4567_89AB_CDEF_F00D, 1'b0};
    vecs[3] = '{16'h0000, 80'hDEAD_BEEF_CAFE_BABE_1234, 1'b0};
    vecs[4] = '{16'h03FF, 80'h1111_1111_1111_1111_1111, 1'b1};
    vecs[5] = '{16'hFFFF, 80'h2222_2222_2222_2222_2222, 1'b1};
    vecs[6] = '{16'h0300, 80'hFFFF_0000_FFFF_0000_A5A5, 1'b0};
    vecs[7] = '{16'h03F7, 80'h3333_3333_3333_3333_3333, 1'b1};
    for (int i = 0; i < 1024; i++) tbmem[i] = '0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_wr_en", 80'(wr_en), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_done", 80'(done_write), 80'(0));
    chk("rst_err", 80'(err), 80'(0));
    chk("rst_address", 80'(address), 80'(0));
    chk("rst_data", 80'(mem_data_in), 80'(0));
    @(negedge clock);
    reset = 1'b1;
    idle(1);

    // Table of records, including the bounds edge cases
    for (int i = 0; i < 8; i++) begin
      start_rec(vecs[i].base, vecs[i].rec, vecs[i].exp_err ? 0 : 5);
      chk("cycle1_busy", 80'(busy), 80'(!vecs[i].exp_err));
      chk("cycle1_wr_en", 80'(wr_en), 80'(!vecs[i].exp_err));
      wait_done(1, vecs[i].exp_err ? 1 : 6, vecs[i].exp_err);
      idle(2);
      if (i == 0) begin
        chk("mem_10", 80'(tbmem[16'h10]), 80'(16'h1111));
        chk("mem_12", 80'(tbmem[16'h12]), 80'(16'h2222));
        chk("mem_14", 80'(tbmem[16'h14]), 80'(16'h3333));
        chk("mem_16", 80'(tbmem[16'h16]), 80'(16'h4444));
        chk("mem_18", 80'(tbmem[16'h18]), 80'(16'h5555));
      end
      if (i == 2) chk("mem_3fe", 80'(tbmem[16'h3FE]), 80'(16'hF00D));
    end

    // Start while busy is ignored; changed inputs do not affect the latched record
    d0 = done_cnt;
    start_rec(16'h0010, 80'h1111_2222_3333_4444_5555, 5);
    idle(1);
    start = 1'b1;
    base_addr = 16'h0100;
    record_in = 80'h9999_8888_7777_6666_5555;
    idle(1);
    start = 1'b0;
    wait_done(3, 6, 1'b0);
    idle(10);
    chk("busy_one_done", 80'(done_cnt - d0), 80'(1));
    chk("busy_no_0100", 80'(tbmem[16'h100]), 80'(0));

    // Back-to-back: start held in the DONE cycle
    d0 = done_cnt;
    start_rec(16'h0020, 80'h0A0A_0B0B_0C0C_0D0D_0E0E, 5);
    wait_done(1, 6, 1'b0);
    start = 1'b1;
    base_addr = 16'h0040;
    record_in = 80'h4040_4141_4242_4343_4444;
    push_record(16'h0040, 80'h4040_4141_4242_4343_4444, 5);
    idle(1);
    start = 1'b0;
    chk("b2b_wr_en", 80'(wr_en), 80'(1));
    chk("b2b_address", 80'(address), 80'(16'h0040));
    wait_done(1, 6, 1'b0);
    idle(2);
    chk("b2b_two_done", 80'(done_cnt - d0), 80'(2));

    // Asynchronous reset during the third write cycle
    for (int a = 16'h10; a <= 16'h18; a++) tbmem[a] = '0;
    d0 = done_cnt;
    start_rec(16'h0010, 80'h1111_2222_3333_4444_5555, 2);
    idle(1);
    idle(1);
    chk("pre_rst_addr", 80'(address), 80'(16'h0014));
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_wr_en", 80'(wr_en), 80'(0));
    chk("mid_rst_busy", 80'(busy), 80'(0));
    idle(2);
    chk("rst_no_done", 80'(done_cnt - d0), 80'(0));
    chk("rst_mem_10", 80'(tbmem[16'h10]), 80'(16'h1111));
    chk("rst_mem_12", 80'(tbmem[16'h12]), 80'(16'h2222));
    chk("rst_mem_14", 80'(tbmem[16'h14]), 80'(0));

    // Start already high when reset releases is taken on the first edge
    base_addr = 16'h0080;
    record_in = 80'h8001_8002_8003_8004_8005;
    start = 1'b1;
    push_record(16'h0080, 80'h8001_8002_8003_8004_8005, 5);
    @(negedge clock);
    reset = 1'b1;
    idle(1);
    start = 1'b0;
    chk("rel_wr_en", 80'(wr_en), 80'(1));
    wait_done(1, 6, 1'b0);
    idle(3);
    chk("mem_88", 80'(tbmem[16'h88]), 80'(16'h8005));
    chk("scoreboard_empty", 80'(exp_q.size()), 80'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
